sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 Parameter DEPTH, default 16, number of storage entries; SHALL be a power of two ≥ 2.
REQ-003 clock  input  1  single clock; all state changes on rising edge except reset.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 w_enable  input  1  write request, sampled at rising clock edge.
REQ-006 r_enable  input  1  read request, sampled at rising clock edge.
REQ-007 write_data  input  DATA_WIDTH  word to store on an accepted write.
REQ-008 read_data  output  DATA_WIDTH  registered word from the most recent accepted read.
REQ-009 full  output  1  high when DEPTH words are stored.
REQ-010 empty  output  1  high when zero words are stored.

Function
REQ-011 Storage: DEPTH x DATA_WIDTH array; write and read pointers each log2(DEPTH)+1 bits (address bits plus wrap bit).
REQ-012 Accepted write: w_enable=1 and full=0 at the edge; write_data stored at write address; write pointer +1.
REQ-013 Accepted read: r_enable=1 and empty=0 at the edge; read_data loads the word at read address on that edge (1-cycle latency); read pointer +1.
REQ-014 read_data SHALL hold its value on every edge without an accepted read.
REQ-015 Write with full=1 SHALL be ignored: no storage change, no pointer change, no error flag.
REQ-016 Read with empty=1 SHALL be ignored: read_data and read pointer unchanged.
REQ-017 Simultaneous read and write with neither flag set: both accepted on the same edge; occupancy unchanged.
REQ-018 Simultaneous request while full: only the read is accepted; full deasserts after the edge.
REQ-019 Simultaneous request while empty: only the write is accepted; no fall-through; read_data unchanged.
REQ-020 empty SHALL equal 1 exactly when the read and write pointers are equal in all bits.
REQ-021 full SHALL equal 1 exactly when the address bits are equal and the wrap bits differ.
REQ-022 full and empty are combinational from the pointer registers; they reflect an edge's accepted operations immediately after that edge.
REQ-023 Pointer address bits wrap from DEPTH-1 to 0; the wrap bit toggles on each wrap. Data order is preserved across wrap-around.
REQ-024 Words are returned strictly in write order (first in, first out).

Reset
REQ-025 reset=1 SHALL immediately, without waiting for a clock edge, clear both pointers to 0 and read_data to 0, giving empty=1 and full=0.
REQ-026 While reset=1, all write and read requests are ignored.
REQ-027 Storage array contents need not be cleared; they are unobservable after reset.
REQ-028 Reset asserted mid-operation discards all stored words; the first accepted read after release returns the first word written after release.

Verification
REQ-029 Assert reset 20 ns, then release -> empty=1, full=0, read_data=0.
REQ-030 16 consecutive writes of 1..16 -> empty=0 after the first edge; full=1 after the 16th edge.
REQ-031 With the FIFO full, w_enable=1 with write_data=0xAA for 2 cycles -> full stays 1; later reads contain no 0xAA.
REQ-032 16 consecutive reads from full -> read_data = 1,2,...,16 on successive edges; empty=1 after the 16th; a 17th read leaves read_data=16.
REQ-033 Fill to 8 words, then 20 cycles of simultaneous read and write -> occupancy stays 8; pointers wrap; output order intact; full=0 and empty=0 throughout.
REQ-034 Assert reset asynchronously between edges while holding 5 words -> empty=1 and read_data=0 before the next edge; no pre-reset word is ever read back.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-in/first-out buffer.
// Pointers carry one extra wrap bit so that "full" and "empty" can be told
// apart when the address bits match. read_data is a register that only
// changes on an accepted read, which gives reads a one-cycle latency.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  w_enable,
  input  logic                  r_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_write;
  logic                  do_read;

  // Status flags come straight from the pointer registers, so they already
  // reflect the operations accepted at the most recent edge.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // A request is accepted only when its flag permits it and reset is low.
  // Gating on the registered flags also covers the cases where both
  // requests arrive together while full (read only) or empty (write only).
  assign do_write = w_enable && !full  && !reset;
  assign do_read  = r_enable && !empty && !reset;

  // Storage array is not reset; its contents are unreachable after a reset
  // because both pointers are cleared together.
  always_ff @(posedge clock) begin
    if (do_write) begin
      mem[wr_ptr[AW-1:0]] <= write_data;
    end
  end

  // Write pointer advances on each accepted write; wrap bit toggles on wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (do_write) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer advances on each accepted read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (do_read) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Output register loads the head word on an accepted read and holds otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      read_data <= '0;
    end else if (do_read) begin
      read_data <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed test of sync_fifo with hand-computed expected values.
module tb_sync_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       w_enable;
  logic       r_enable;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .w_enable   (w_enable),
    .r_enable   (r_enable),
    .write_data (write_data),
    .read_data  (read_data),
    .full       (full),
    .empty      (empty)
  );

  // 10 ns clock, first rising edge at 5 ns.
  always #5 clock = ~clock;

  // Count one comparison and report it if observed differs from expected.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one set of requests, let one rising edge pass, sample 1 ns later.
  task automatic cycle(input logic we, input logic re, input logic [7:0] wd);
    w_enable   = we;
    r_enable   = re;
    write_data = wd;
    @(posedge clock);
    #1;
    w_enable   = 1'b0;
    r_enable   = 1'b0;
    write_data = 8'h00;
  endtask

  initial begin
    reset      = 1'b1;
    w_enable   = 1'b0;
    r_enable   = 1'b0;
    write_data = 8'h00;

    // Reset for 20 ns, release between edges.
    #22;
    reset = 1'b0;
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_rdata", 32'(read_data), 32'd0);

    // Fill with 1..16.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      if (i == 1) check("fill_empty_after_first", 32'(empty), 32'd0);
      if (i == 15) check("fill_full_after_15", 32'(full), 32'd0);
    end
    check("fill_full_after_16", 32'(full), 32'd1);
    check("fill_empty_after_16", 32'(empty), 32'd0);

    // Writes while full are dropped.
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 1'b0, 8'hAA);
      check("wr_when_full_full", 32'(full), 32'd1);
    end
    check("wr_when_full_rdata_hold", 32'(read_data), 32'd0);

    // Drain 16 words in order; no 0xAA may appear.
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check("drain_rdata", 32'(read_data), 32'(i));
      if (i == 1) check("drain_full_clears", 32'(full), 32'd0);
    end
    check("drain_empty_after_16", 32'(empty), 32'd1);

    // Read while empty leaves read_data alone.
    cycle(1'b0, 1'b1, 8'h00);
    check("rd_when_empty_rdata", 32'(read_data), 32'd16);
    check("rd_when_empty_empty", 32'(empty), 32'd1);

    // Simultaneous request while empty: write only, no fall-through.
    cycle(1'b1, 1'b1, 8'h55);
    check("both_empty_rdata_hold", 32'(read_data), 32'd16);
    check("both_empty_empty", 32'(empty), 32'd0);
    cycle(1'b0, 1'b1, 8'h00);
    check("both_empty_word_read", 32'(read_data), 32'h55);
    check("both_empty_then_empty", 32'(empty), 32'd1);

    // Simultaneous request while full: read only, full clears.
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i));
    check("refill_full", 32'(full), 32'd1);
    cycle(1'b1, 1'b1, 8'hEE);
    check("both_full_rdata", 32'(read_data), 32'h80);
    check("both_full_full_clears", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check("both_full_drain", 32'(read_data), 32'(8'h80 + i));
    end
    check("both_full_drain_empty", 32'(empty), 32'd1);

    // Hold 8 words, then 20 cycles of simultaneous read/write across the wrap.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i));
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 8'(8'h28 + i));
      check("stream_rdata", 32'(read_data), 32'(8'h20 + i));
      check("stream_full", 32'(full), 32'd0);
      check("stream_empty", 32'(empty), 32'd0);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 8'h00);
      check("stream_tail", 32'(read_data), 32'(8'h34 + i));
    end
    check("stream_tail_empty", 32'(empty), 32'd1);

    // Async reset while holding words: flags and output clear before any edge.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'(8'h61 + i));
    cycle(1'b0, 1'b1, 8'h00);
    check("pre_rst_rdata", 32'(read_data), 32'h61);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_full", 32'(full), 32'd0);
    check("async_rst_rdata", 32'(read_data), 32'd0);
    // Requests during reset are ignored.
    cycle(1'b1, 1'b1, 8'h99);
    check("in_rst_empty", 32'(empty), 32'd1);
    check("in_rst_rdata", 32'(read_data), 32'd0);
    reset = 1'b0;
    #1;
    cycle(1'b1, 1'b0, 8'h71);
    check("post_rst_empty", 32'(empty), 32'd0);
    cycle(1'b0, 1'b1, 8'h00);
    check("post_rst_first_word", 32'(read_data), 32'h71);
    check("post_rst_empty_again", 32'(empty), 32'd1);
    cycle(1'b0, 1'b1, 8'h00);
    check("post_rst_no_stale", 32'(read_data), 32'h71);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
